// File: rtl/dna_reader_pkg.sv
// Shared types and helpers for the device DNA reader.
// State encoding, default DNA width and counter-width helper.
package dna_reader_pkg;

    localparam int DNA_BITS_DEFAULT = 57;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } dna_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dna_clk_gen.sv
// Divided DNA_PORT clock with rise/fall tick strobes.
// Held low with a cleared divider whenever not enabled.
module dna_clk_gen
    import dna_reader_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic dna_clk_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    localparam int DW = cnt_width(CLK_DIV);
    localparam logic [DW-1:0] TERM = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic          dclk_q;
    logic          term;

    assign term        = en_i && (div_q == TERM);
    assign rise_tick_o = term && !dclk_q;
    assign fall_tick_o = term && dclk_q;
    assign dna_clk_o   = dclk_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= '0;
            dclk_q <= 1'b0;
        end else if (!en_i) begin
            div_q  <= '0;
            dclk_q <= 1'b0;
        end else if (term) begin
            div_q  <= '0;
            dclk_q <= ~dclk_q;
        end else begin
            div_q  <= div_q + 1'b1;
        end
    end

endmodule

// File: rtl/dna_port_reader.sv
// DNA_PORT controller: drives READ/SHIFT and the divided clock,
// deserialises DOUT MSB-first and publishes the value with a valid flag.
module dna_port_reader
    import dna_reader_pkg::*;
#(
    parameter int DNA_BITS   = DNA_BITS_DEFAULT,
    parameter int CLK_DIV    = 1,
    parameter bit AUTO_START = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    output logic                dna_clk_o,
    output logic                dna_read_o,
    output logic                dna_shift_o,
    output logic                dna_din_o,
    input  logic                dna_dout_i,
    output logic                busy_o,
    output logic                dna_valid_o,
    output logic [DNA_BITS-1:0] dna_value_o
);

    localparam int BW = cnt_width(DNA_BITS);
    localparam logic [BW-1:0] LAST = BW'(DNA_BITS - 1);

    dna_state_e          state_q, state_d;
    logic                read_q, read_d;
    logic                shift_q, shift_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic [DNA_BITS-1:0] value_q, value_d;
    logic [BW-1:0]       bitcnt_q, bitcnt_d;
    logic                last_q, last_d;
    logic                auto_q, auto_d;
    logic                clk_en;
    logic                rise_tick;
    logic                fall_tick;

    assign clk_en = (state_q == ST_READ) || (state_q == ST_SHIFT);

    dna_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (clk_en),
        .dna_clk_o   (dna_clk_o),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick)
    );

    always_comb begin
        state_d  = state_q;
        read_d   = read_q;
        shift_d  = shift_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        value_d  = value_q;
        bitcnt_d = bitcnt_q;
        last_d   = last_q;
        auto_d   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i || (auto_q && state_q == ST_IDLE)) begin
                    state_d = ST_READ;
                    read_d  = 1'b1;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    value_d = '0;
                end
            end
            ST_READ: begin
                if (fall_tick) begin
                    state_d  = ST_SHIFT;
                    read_d   = 1'b0;
                    shift_d  = 1'b1;
                    bitcnt_d = '0;
                    last_d   = 1'b0;
                end
            end
            ST_SHIFT: begin
                // DOUT still shows the pre-edge bit, so this is MSB-first
                if (rise_tick && !last_q) begin
                    value_d = {value_q[DNA_BITS-2:0], dna_dout_i};
                    if (bitcnt_q == LAST) last_d = 1'b1;
                    else bitcnt_d = bitcnt_q + 1'b1;
                end else if (fall_tick && last_q) begin
                    state_d = ST_DONE;
                    shift_d = 1'b0;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            read_q   <= 1'b0;
            shift_q  <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            value_q  <= '0;
            bitcnt_q <= '0;
            last_q   <= 1'b0;
            auto_q   <= AUTO_START;
        end else begin
            state_q  <= state_d;
            read_q   <= read_d;
            shift_q  <= shift_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            value_q  <= value_d;
            bitcnt_q <= bitcnt_d;
            last_q   <= last_d;
            auto_q   <= auto_d;
        end
    end

    assign dna_read_o  = read_q;
    assign dna_shift_o = shift_q;
    assign dna_din_o   = 1'b0;
    assign busy_o      = busy_q;
    assign dna_valid_o = valid_q;
    assign dna_value_o = value_q;

endmodule
